// File: rtl/flt2fix_unpack.sv
// flt2fix_unpack: reads a half-precision float from data_mem, converts it to a
// 16-bit two's-complement integer and writes the integer back to data_mem.
// Float layout: sign [15], exponent [14:10] (bias BIAS), mantissa [9:0].
// Optional build macro FLT2FIX_ROUND_EN: round to nearest-even instead of
// truncating toward zero.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        conversion request, sampled only in IDLE
//   done         conversion complete, held until the next accepted start
//   mem_addr     data_mem address (0 outside the memory-access states)
//   mem_rd_data  data_mem read data, combinational on mem_addr
//   mem_wr_en    data_mem write strobe (WR_LO/WR_HI only)
//   mem_wr_data  data_mem write data
module flt2fix_unpack #(
    parameter logic [7:0]  SRC_ADDR = 8'd8,
    parameter logic [7:0]  DST_ADDR = 8'd12,
    parameter int unsigned BIAS     = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);

    localparam int unsigned MAG_W = 16;
    localparam int unsigned EXP_W = 5;
    localparam int unsigned SH_W  = 6;

    // Exponent at which the 11-bit significand already is the integer value.
    localparam logic [EXP_W-1:0] ALIGN_E = EXP_W'(BIAS + 10);
    // Smallest exponent whose value cannot fit in a signed 16-bit integer.
    localparam logic [EXP_W-1:0] SAT_E   = EXP_W'(BIAS + 15);
    localparam logic [EXP_W-1:0] BIAS_E  = EXP_W'(BIAS);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        ALIGN,
        NEG,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    state_t                  state;
    logic [7:0]              mant_lo;
    logic [MAG_W-1:0]        mag;
    logic signed [SH_W-1:0]  sh;
    logic                    sign;
    logic                    sat;
    logic [MAG_W-1:0]        result;
`ifdef FLT2FIX_ROUND_EN
    logic                    guard;
    logic                    sticky;
`endif

    logic                    sign_c;
    logic [EXP_W-1:0]        exp_c;
    logic [MAG_W-1:0]        m11_c;
    logic signed [SH_W-1:0]  sh_c;
    logic [MAG_W-1:0]        mag_rnd_c;
    logic [MAG_W-1:0]        result_c;

    // Decode of the high byte as it arrives in RD_HI.
    always_comb begin
        sign_c = mem_rd_data[7];
        exp_c  = mem_rd_data[6:2];
        m11_c  = {5'b0, 1'b1, mem_rd_data[1:0], mant_lo};
        sh_c   = $signed({1'b0, exp_c}) - $signed({1'b0, ALIGN_E});
    end

    // Final rounding, saturation and negation of the aligned magnitude.
    always_comb begin
        mag_rnd_c = mag;
`ifdef FLT2FIX_ROUND_EN
        if (guard && (sticky || mag[0])) begin
            mag_rnd_c = mag + MAG_W'(1);
        end
`endif
        if (sat || mag_rnd_c[MAG_W-1]) begin
            result_c = sign ? 16'h8000 : 16'h7FFF;
        end else begin
            // Zero magnitude negates to zero, so no negative zero appears.
            result_c = sign ? (~mag_rnd_c + MAG_W'(1)) : mag_rnd_c;
        end
    end

    // Conversion sequencer with registered memory-port and done outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            done        <= 1'b0;
            mem_addr    <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
            mant_lo     <= '0;
            mag         <= '0;
            sh          <= '0;
            sign        <= 1'b0;
            sat         <= 1'b0;
            result      <= '0;
`ifdef FLT2FIX_ROUND_EN
            guard       <= 1'b0;
            sticky      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        done     <= 1'b0;
                        mem_addr <= SRC_ADDR;
                        state    <= RD_LO;
                    end
                end

                RD_LO: begin
                    mant_lo  <= mem_rd_data;
                    mem_addr <= SRC_ADDR + 8'd1;
                    state    <= RD_HI;
                end

                RD_HI: begin
                    mem_addr <= '0;
                    sign     <= sign_c;
                    sat      <= 1'b0;
                    mag      <= m11_c;
                    sh       <= sh_c;
`ifdef FLT2FIX_ROUND_EN
                    guard    <= 1'b0;
                    sticky   <= 1'b0;
`endif
                    if (exp_c == '0) begin
                        // Zero and subnormals are flushed.
                        mag   <= '0;
                        state <= NEG;
                    end else if (exp_c < BIAS_E) begin
                        mag   <= '0;
`ifdef FLT2FIX_ROUND_EN
                        // [0.5,1): exactly 0.5 ties to even (0), above rounds to 1.
                        if ((exp_c == BIAS_E - 5'd1) && (m11_c[9:0] != '0)) begin
                            mag <= MAG_W'(1);
                        end
`endif
                        state <= NEG;
                    end else if (exp_c >= SAT_E) begin
                        sat   <= 1'b1;
                        state <= NEG;
                    end else if (sh_c == '0) begin
                        state <= NEG;
                    end else begin
                        state <= ALIGN;
                    end
                end

                ALIGN: begin
                    if (sh > 6'sd0) begin
                        mag <= mag << 1;
                        sh  <= sh - 6'sd1;
                        if (sh == 6'sd1) begin
                            state <= NEG;
                        end
                    end else begin
                        mag <= mag >> 1;
                        sh  <= sh + 6'sd1;
`ifdef FLT2FIX_ROUND_EN
                        sticky <= sticky | guard;
                        guard  <= mag[0];
`endif
                        if (sh == -6'sd1) begin
                            state <= NEG;
                        end
                    end
                end

                NEG: begin
                    result      <= result_c;
                    mem_addr    <= DST_ADDR;
                    mem_wr_data <= result_c[7:0];
                    mem_wr_en   <= 1'b1;
                    state       <= WR_LO;
                end

                WR_LO: begin
                    mem_addr    <= DST_ADDR + 8'd1;
                    mem_wr_data <= result[15:8];
                    state       <= WR_HI;
                end

                WR_HI: begin
                    mem_addr    <= '0;
                    mem_wr_en   <= 1'b0;
                    mem_wr_data <= '0;
                    state       <= DONE;
                end

                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flt2fix_unpack.sv
// tb_flt2fix_unpack: self-checking bench for flt2fix_unpack.
// Holds a byte-wide data_mem model, runs directed and random conversions and
// compares results, latency and write traffic against an arithmetic model.
// Honours FLT2FIX_ROUND_EN the same way as the design.
module tb_flt2fix_unpack;

    logic       clk;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    logic [7:0] mem [0:255];
    int         wr_count;
    int         bad_wr;
    int         n_cmp;
    int         n_err;

    flt2fix_unpack dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];

    // data_mem: synchronous write, plus write-traffic bookkeeping.
    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
            wr_count = wr_count + 1;
            if (mem_addr != 8'd12 && mem_addr != 8'd13) bad_wr = bad_wr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Value = significand * 2^(exp-25), converted with plain integer arithmetic.
    function automatic logic [15:0] ref_model(input logic [15:0] f);
        int     e;
        longint m, q, r, den;
        bit     s;
        s = f[15];
        e = int'(f[14:10]);
        m = longint'({1'b1, f[9:0]});
        if (e == 0) return 16'h0000;
        if (e == 31) return s ? 16'h8000 : 16'h7FFF;
        if (e >= 25) begin
            q = m * (longint'(1) << (e - 25));
        end else begin
            den = longint'(1) << (25 - e);
            q = m / den;
            r = m % den;
`ifdef FLT2FIX_ROUND_EN
            if ((2 * r > den) || ((2 * r == den) && (q % 2 == 1))) q = q + 1;
`endif
        end
        if (q > 32767) return s ? 16'h8000 : 16'h7FFF;
        return s ? 16'(-q) : 16'(q);
    endfunction

    function automatic int ref_lat(input logic [15:0] f);
        int e;
        e = int'(f[14:10]);
        if (e >= 15 && e <= 29) return 6 + ((e > 25) ? (e - 25) : (25 - e));
        return 6;
    endfunction

    task automatic run_conv(input logic [15:0] f, output logic [15:0] res, output int lat);
        mem[8] = f[7:0];
        mem[9] = f[15:8];
        wr_count = 0;
        bad_wr = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (done) lat = k;
        end
        res = {mem[13], mem[12]};
    endtask

    logic [15:0] dir_f   [12];
    logic [15:0] dir_exp [12];
    int          dir_lat [12];

    initial begin
        logic [15:0] res;
        logic [15:0] f;
        int          lat;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        wr_count = 0;
        bad_wr = 0;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        start = 1'b0;

        dir_f   = '{16'h3C00, 16'hC500, 16'h77FF, 16'h7BFF, 16'hFC00, 16'h7E00,
                    16'h3E00, 16'h4100, 16'h3800, 16'h0001, 16'h8000, 16'hB400};
`ifdef FLT2FIX_ROUND_EN
        dir_exp = '{16'h0001, 16'hFFFB, 16'h7FF0, 16'h7FFF, 16'h8000, 16'h7FFF,
                    16'h0002, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
`else
        dir_exp = '{16'h0001, 16'hFFFB, 16'h7FF0, 16'h7FFF, 16'h8000, 16'h7FFF,
                    16'h0001, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
`endif
        dir_lat = '{16, 14, 10, 6, 6, 6, 16, 15, 6, 6, 6, 6};

        // Reset values.
        #2;
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wr_data", 32'(mem_wr_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 12; i++) begin
            run_conv(dir_f[i], res, lat);
            check($sformatf("dir_res_%04h", dir_f[i]), 32'(res), 32'(dir_exp[i]));
            check($sformatf("dir_lat_%04h", dir_f[i]), 32'(lat), 32'(dir_lat[i]));
            check($sformatf("dir_wrs_%04h", dir_f[i]), 32'(wr_count), 32'd2);
            check($sformatf("dir_badwr_%04h", dir_f[i]), 32'(bad_wr), 32'd0);
        end

        // done holds until the next accepted start.
        repeat (4) @(posedge clk);
        #1 check("done_hold", 32'(done), 32'd1);
        check("idle_addr", 32'(mem_addr), 32'd0);

        // start held high: second conversion begins on the cycle after done.
        mem[8] = 8'h00;
        mem[9] = 8'h3C;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 lat = -1;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (done) lat = k;
        end
        check("hold_lat1", 32'(lat), 32'd16);
        @(posedge clk);
        #1 check("hold_retrig", 32'(done), 32'd0);
        lat = -1;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (done) lat = k;
        end
        start = 1'b0;
        check("hold_lat2", 32'(lat), 32'd16);
        check("hold_res", 32'({mem[13], mem[12]}), 32'h0001);

        // Reset during ALIGN aborts without touching the destination.
        mem[8]  = 8'h00;
        mem[9]  = 8'h3C;
        mem[12] = 8'hA5;
        mem[13] = 8'h5A;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort_done", 32'(done), 32'd0);
        check("abort_wr_en", 32'(mem_wr_en), 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd0);
        repeat (3) @(posedge clk);
        #1 check("abort_mem", 32'({mem[13], mem[12]}), 32'h5AA5);
        @(negedge clk);
        reset = 1'b1;
        run_conv(16'h3C00, res, lat);
        check("after_abort_res", 32'(res), 32'h0001);
        check("after_abort_lat", 32'(lat), 32'd16);

        // Random floats against the arithmetic model.
        for (int i = 0; i < 60; i++) begin
            f = 16'($urandom);
            if (i % 2 == 0) f[14:10] = 5'($urandom_range(13, 31));
            run_conv(f, res, lat);
            check($sformatf("rnd_res_%04h", f), 32'(res), 32'(ref_model(f)));
            check($sformatf("rnd_lat_%04h", f), 32'(lat), 32'(ref_lat(f)));
            check($sformatf("rnd_wrs_%04h", f), 32'(wr_count), 32'd2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
